instr_fetch_loader: RTL and testbench

//  Initiator for the instruction-memory port. Drives we_IM/address_IM/dataIM and consumes out_IM.

---
 rtl/CPU_package.sv | 14 +
 rtl/instr_fetch_loader.sv | 135 +++++++++++++
 tb/tb_instr_fetch_loader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/CPU_package.sv
// Shared CPU-wide widths and the fetch/loader state encoding.
package CPU_package;

    localparam int DATA_WIDTH        = 32;
    localparam int ADDRESS_WIDTH     = 8;
    localparam int ADDRESS_MAX_WIDTH = 2 ** ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2
    } ifl_state_t;

endpackage

// File: rtl/instr_fetch_loader.sv
// Instruction-memory initiator: boot-loads a word stream into IM (LOAD) or
// streams sequential instructions to decode with stall and branch redirect (FETCH).
module instr_fetch_loader
    import CPU_package::*;
#(
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    input  logic [ADDRESS_WIDTH-1:0] load_len,
    input  logic                     ld_valid,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_ready,
    output logic                     load_done,
    input  logic                     fetch_en,
    input  logic                     stall,
    input  logic                     branch_valid,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    output logic                     we_IM,
    output logic [ADDRESS_WIDTH-1:0] address_IM,
    output logic [DATA_WIDTH-1:0]    dataIM,
    input  logic [DATA_WIDTH-1:0]    out_IM,
    output logic                     instr_valid,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     busy
);

    ifl_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                     valid_q, valid_d;
    logic                     load_done_q, load_done_d;
    logic [ADDRESS_WIDTH-1:0] fetch_addr;
    logic                     hold_pc;

    // Branch beats stall; a stall only re-reads once a valid instruction is on show.
    assign fetch_addr = branch_valid       ? branch_target :
                        (stall && valid_q) ? instr_pc_q    : pc_q;
    assign hold_pc    = stall && valid_q && !branch_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            ptr_q       <= '0;
            cnt_q       <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        load_done_d = 1'b0;
        we_IM       = 1'b0;
        address_IM  = '0;
        dataIM      = '0;
        ld_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = load_addr;
                    cnt_d   = load_len;
                end else if (fetch_en) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                    valid_d = 1'b0;
                end
            end
            LOAD: begin
                address_IM = ptr_q;
                dataIM     = ld_data;
                // A zero-length load has nothing to accept and finishes immediately.
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    load_done_d = 1'b1;
                end else begin
                    ld_ready = 1'b1;
                    we_IM    = ld_valid;
                    if (ld_valid) begin
                        ptr_d = ptr_q + 1'b1;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == ADDRESS_WIDTH'(1)) begin
                            state_d     = IDLE;
                            load_done_d = 1'b1;
                        end
                    end
                end
            end
            FETCH: begin
                address_IM = fetch_addr;
                instr_pc_d = fetch_addr;
                valid_d    = 1'b1;
                if (!hold_pc) begin
                    pc_d = fetch_addr + 1'b1;
                end
                if (!fetch_en) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_done   = load_done_q;
    assign instr_valid = valid_q;
    assign instr       = out_IM;
    assign instr_pc    = instr_pc_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Directed bench: instr_fetch_loader paired with a simple synchronous-read IM model.
module tb_instr_fetch_loader;
    import CPU_package::*;

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [AW-1:0] load_addr;
    logic [AW-1:0] load_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          load_done;
    logic          fetch_en;
    logic          stall;
    logic          branch_valid;
    logic [AW-1:0] branch_target;
    logic          we_IM;
    logic [AW-1:0] address_IM;
    logic [DW-1:0] dataIM;
    logic [DW-1:0] out_IM;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [DW-1:0] A0 = 32'hA000_0000;
    localparam logic [DW-1:0] A1 = 32'hA000_0001;
    localparam logic [DW-1:0] A2 = 32'hA000_0002;

    logic [DW-1:0] mem [ADDRESS_MAX_WIDTH];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we_IM) mem[address_IM] <= dataIM;
        out_IM <= mem[address_IM];
    end

    instr_fetch_loader #(.RESET_PC(8'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_addr(load_addr), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .load_done(load_done),
        .fetch_en(fetch_en), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .we_IM(we_IM), .address_IM(address_IM), .dataIM(dataIM), .out_IM(out_IM),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .busy(busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, we_IM, ld_ready, instr_valid, load_done} !== 5'b0 || address_IM !== '0 || dataIM !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got busy=%b we=%b rdy=%b iv=%b done=%b addr=%h data=%h want all 0",
                     busy, we_IM, ld_ready, instr_valid, load_done, address_IM, dataIM);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset done");
    endtask

    task automatic test_load();
        load_start = 1'b1; load_addr = 8'd4; load_len = 8'd3;
        @(negedge clk);
        load_start = 1'b0; ld_valid = 1'b1; ld_data = A0;
        #1;
        tests_run++;
        if ({busy, ld_ready, we_IM} !== 3'b111 || address_IM !== 8'd4 || dataIM !== A0) begin
            tests_failed++;
            $display("FAIL load_word0 got busy=%b rdy=%b we=%b addr=%0d data=%h want 1 1 1 4 %h",
                     busy, ld_ready, we_IM, address_IM, dataIM, A0);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        tests_run++;
        if (we_IM !== 1'b0 || address_IM !== 8'd5) begin
            tests_failed++;
            $display("FAIL load_gap got we=%b addr=%0d want 0 5", we_IM, address_IM);
        end
        @(negedge clk);
        ld_valid = 1'b1; ld_data = A1;
        @(negedge clk);
        ld_data = A2;
        #1;
        tests_run++;
        if (address_IM !== 8'd6 || load_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_word2 got addr=%0d done=%b want 6 0", address_IM, load_done);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        tests_run++;
        if (load_done !== 1'b1 || busy !== 1'b0 || we_IM !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_done_pulse got done=%b busy=%b we=%b want 1 0 0", load_done, busy, we_IM);
        end
        @(negedge clk);
        tests_run++;
        if (load_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_done_width got %b want 0", load_done);
        end
        tests_run++;
        if (mem[4] !== A0 || mem[5] !== A1 || mem[6] !== A2) begin
            tests_failed++;
            $display("FAIL load_mem got %h %h %h want %h %h %h", mem[4], mem[5], mem[6], A0, A1, A2);
        end
        $display("[TB] load of 3 words at 4 done");
    endtask

    task automatic test_load_zero();
        load_start = 1'b1; load_addr = 8'd20; load_len = 8'd0;
        @(negedge clk);
        load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        #1;
        tests_run++;
        if (we_IM !== 1'b0 || busy !== 1'b1 || load_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_load got we=%b busy=%b done=%b want 0 1 0", we_IM, busy, load_done);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        tests_run++;
        if (load_done !== 1'b1 || busy !== 1'b0 || we_IM !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_done got done=%b busy=%b we=%b want 1 0 0", load_done, busy, we_IM);
        end
        @(negedge clk);
        $display("[TB] zero-length load done");
    endtask

    task automatic test_fetch_seq();
        logic [AW-1:0] exp_pc [3];
        logic [DW-1:0] exp_in [3];
        exp_pc[0] = 8'd4; exp_pc[1] = 8'd5; exp_pc[2] = 8'd6;
        exp_in[0] = A0;   exp_in[1] = A1;   exp_in[2] = A2;
        fetch_en = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || instr_valid !== 1'b0 || we_IM !== 1'b0 || address_IM !== 8'd4) begin
            tests_failed++;
            $display("FAIL fetch_first_cycle got busy=%b iv=%b we=%b addr=%0d want 1 0 0 4",
                     busy, instr_valid, we_IM, address_IM);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) fetch_en = 1'b0;
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instr !== exp_in[i]) begin
                tests_failed++;
                $display("FAIL fetch_seq%0d got iv=%b pc=%0d instr=%h want 1 %0d %h",
                         i, instr_valid, instr_pc, instr, exp_pc[i], exp_in[i]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_exit got busy=%b iv=%b want 0 0", busy, instr_valid);
        end
        $display("[TB] sequential fetch 4..6 done");
    endtask

    task automatic test_stall_branch();
        fetch_en = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b1;
        // Four cycles show pc 5: three stalled ones plus the one where decode accepts.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall = 1'b0;
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'd5 || instr !== A1) begin
                tests_failed++;
                $display("FAIL stall_hold%0d got iv=%b pc=%0d instr=%h want 1 5 %h",
                         i, instr_valid, instr_pc, instr, A1);
            end
            @(negedge clk);
        end
        tests_run++;
        if (instr_pc !== 8'd6 || instr !== A2) begin
            tests_failed++;
            $display("FAIL stall_release got pc=%0d instr=%h want 6 %h", instr_pc, instr, A2);
        end
        branch_valid = 1'b1; branch_target = 8'd4; stall = 1'b1;
        @(negedge clk);
        branch_valid = 1'b0; stall = 1'b0;
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'd4 || instr !== A0) begin
            tests_failed++;
            $display("FAIL branch_target got iv=%b pc=%0d instr=%h want 1 4 %h", instr_valid, instr_pc, instr, A0);
        end
        @(negedge clk);
        fetch_en = 1'b0;
        tests_run++;
        if (instr_pc !== 8'd5 || instr !== A1) begin
            tests_failed++;
            $display("FAIL branch_next got pc=%0d instr=%h want 5 %h", instr_pc, instr, A1);
        end
        @(negedge clk);
        $display("[TB] stall and branch done");
    endtask

    task automatic test_wrap();
        load_start = 1'b1; load_addr = 8'd255; load_len = 8'd2;
        @(negedge clk);
        load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hB0B0_00FF;
        @(negedge clk);
        ld_data = 32'hB0B0_0000;
        @(negedge clk);
        ld_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem[255] !== 32'hB0B0_00FF || mem[0] !== 32'hB0B0_0000) begin
            tests_failed++;
            $display("FAIL load_wrap got mem255=%h mem0=%h want b0b000ff b0b00000", mem[255], mem[0]);
        end
        fetch_en = 1'b1;
        @(negedge clk);
        branch_valid = 1'b1; branch_target = 8'd255;
        @(negedge clk);
        branch_valid = 1'b0;
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'd255 || instr !== 32'hB0B0_00FF) begin
            tests_failed++;
            $display("FAIL fetch_top got iv=%b pc=%0d instr=%h want 1 255 b0b000ff", instr_valid, instr_pc, instr);
        end
        @(negedge clk);
        fetch_en = 1'b0;
        tests_run++;
        if (instr_pc !== 8'd0 || instr !== 32'hB0B0_0000) begin
            tests_failed++;
            $display("FAIL pc_wrap got pc=%0d instr=%h want 0 b0b00000", instr_pc, instr);
        end
        @(negedge clk);
        $display("[TB] address wrap done");
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1; load_addr = 8'd12; load_len = 8'd4;
        @(negedge clk);
        load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hC0C0_0012;
        @(negedge clk);
        ld_data = 32'hC0C0_0013;
        @(negedge clk);
        ld_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, we_IM, ld_ready, load_done, instr_valid} !== 5'b0 || address_IM !== '0 || dataIM !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_load got busy=%b we=%b rdy=%b done=%b iv=%b addr=%h data=%h want all 0",
                     busy, we_IM, ld_ready, load_done, instr_valid, address_IM, dataIM);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (load_done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL no_done_after_abort%0d got done=%b busy=%b want 0 0", i, load_done, busy);
            end
        end
        tests_run++;
        if (mem[12] !== 32'hC0C0_0012 || mem[13] !== 32'hC0C0_0013) begin
            tests_failed++;
            $display("FAIL abort_mem got %h %h want c0c00012 c0c00013", mem[12], mem[13]);
        end
        $display("[TB] reset during load done");
    endtask

    task automatic test_priority();
        load_start = 1'b1; fetch_en = 1'b1; load_addr = 8'd30; load_len = 8'd1;
        @(negedge clk);
        load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hD0D0_0030;
        #1;
        tests_run++;
        if (busy !== 1'b1 || ld_ready !== 1'b1 || instr_valid !== 1'b0 || we_IM !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_over_fetch got busy=%b rdy=%b iv=%b we=%b want 1 1 0 1", busy, ld_ready, instr_valid, we_IM);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        fetch_en = 1'b0;
        #1;
        tests_run++;
        if (load_done !== 1'b1 || mem[30] !== 32'hD0D0_0030) begin
            tests_failed++;
            $display("FAIL priority_load_done got done=%b mem30=%h want 1 d0d00030", load_done, mem[30]);
        end
        repeat (2) @(negedge clk);
        $display("[TB] load_start priority over fetch_en done");
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_addr = '0; load_len = '0;
        ld_valid = 1'b0; ld_data = '0; fetch_en = 1'b0; stall = 1'b0;
        branch_valid = 1'b0; branch_target = '0;
        test_reset();
        test_load();
        test_load_zero();
        test_fetch_seq();
        test_stall_branch();
        test_wrap();
        test_reset_mid_load();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
